// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter and next-PC sequencer for the fetch path
// Optional branch delay slot: define PC_SEQ_DELAY_SLOT_EN.
module pc_sequencer #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  jump,
  input  logic                  jump_reg,
  input  logic                  branch,
  input  logic                  branch_cond,
  input  logic [25:0]           jump_index,
  input  logic [15:0]           branch_offset,
  input  logic [ADDR_WIDTH-1:0] reg_target,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_plus4,
  output logic                  redirect_taken,
  output logic                  fault,
  output logic [CNT_WIDTH-1:0]  redirect_count
);

`ifdef PC_SEQ_DELAY_SLOT_EN
  typedef enum logic [0:0] {RUN, SLOT} state_t;
  logic [ADDR_WIDTH-1:0] slot_target;
`else
  typedef enum logic [0:0] {RUN} state_t;
`endif

  state_t                state;
  logic [27:0]           jump_low;
  logic [ADDR_WIDTH-1:0] jump_target;
  logic [31:0]           branch_off_full;
  logic [ADDR_WIDTH-1:0] branch_target;
  logic [ADDR_WIDTH-1:0] target;
  logic                  misaligned;
  logic                  take_req;
  logic                  active;

  assign pc_plus4 = pc + ADDR_WIDTH'(4);
  assign jump_low = {jump_index, 2'b00};

  // Region bits above 28 come from the sequential PC only when the PC is that wide
  generate
    if (ADDR_WIDTH > 28) begin : g_wide_jump
      assign jump_target = {pc_plus4[ADDR_WIDTH-1:28], jump_low};
    end else begin : g_narrow_jump
      assign jump_target = jump_low[ADDR_WIDTH-1:0];
    end
  endgenerate

  assign branch_off_full = {{14{branch_offset[15]}}, branch_offset, 2'b00};
  assign branch_target   = pc_plus4 + branch_off_full[ADDR_WIDTH-1:0];

  // A misaligned jr outranks every other redirect and turns into a fault instead
  assign misaligned = jump_reg && (reg_target[1:0] != 2'b00);
  assign take_req   = jump_reg || jump || (branch && branch_cond);
  assign target     = jump_reg ? reg_target : (jump ? jump_target : branch_target);

  // Decisions are only made in RUN while neither stalled nor faulted
  assign active         = !stall && !fault && (state == RUN);
  assign redirect_taken = active && take_req && !misaligned;

  // Single sequencer: pc, fault, redirect counter and delay-slot state
  always_ff @(posedge clk) begin
    if (reset) begin
      pc             <= RESET_PC;
      fault          <= 1'b0;
      redirect_count <= '0;
      state          <= RUN;
`ifdef PC_SEQ_DELAY_SLOT_EN
      slot_target    <= '0;
`endif
    end else if (!stall && !fault) begin
      case (state)
        RUN: begin
          if (misaligned) begin
            fault <= 1'b1;
          end else if (take_req) begin
            if (redirect_count != '1) redirect_count <= redirect_count + 1'b1;
`ifdef PC_SEQ_DELAY_SLOT_EN
            pc          <= pc_plus4;
            slot_target <= target;
            state       <= SLOT;
`else
            pc <= target;
`endif
          end else begin
            pc <= pc_plus4;
          end
        end
`ifdef PC_SEQ_DELAY_SLOT_EN
        SLOT: begin
          pc    <= slot_target;
          state <= RUN;
        end
`endif
        default: state <= RUN;
      endcase
    end
  end

endmodule
